// File: rtl/pipe_reg_if.sv
// pipe_reg_if: valid/ready stream bundle (upstream, downstream, flush) for pipe_reg.
interface pipe_reg_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, flush, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, flush, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready register pipeline with bubble collapsing and flush.
// Define PIPE_REG_OCC_EN to add the occupancy output.
module pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic clk,
    input logic rst_n,
    pipe_reg_if.slave bus
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
    logic [DEPTH-1:0] valid;
    logic [DEPTH:0]   ready;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] src  [DEPTH];
    always_comb begin
        ready[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) ready[i] = ~valid[i] | ready[i+1];
    end
    assign bus.in_ready = ready[0] & ~bus.flush;
    always_comb begin
        up_valid[0] = bus.in_valid & ready[0] & ~bus.flush;
        src[0]      = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_valid[i] = valid[i-1];
            src[i]      = data[i-1];
        end
    end
    // flush wins: valid bits drop, data registers keep their contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.flush) valid[i] <= 1'b0;
                else if (ready[i]) valid[i] <= up_valid[i];
                if (ready[i] && up_valid[i] && !bus.flush) data[i] <= src[i];
            end
        end
    end
    assign bus.out_valid = valid[DEPTH-1];
    assign bus.out_data  = data[DEPTH-1];
`ifdef PIPE_REG_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy += OW'(valid[i]);
    end
`endif
endmodule
